// File: rtl/nn1_pkg.sv
// Shared parameters and state encoding for the nn1 layer-2 neuron.
// Also provides the accumulator width helper used by later layers.
package nn1_pkg;

    localparam int NUM_IN     = 32;
    localparam int IN_BIT     = 4;
    localparam int WEIGHT_BIT = 4;
    localparam int BIAS_BIT   = 6;
    localparam int OUT_BIT    = 4;
    localparam int SHIFT      = 3;

    function automatic int acc_width(int ib, int wb, int n);
        return ib + wb + 1 + $clog2(n);
    endfunction

    localparam int ACC_BIT = acc_width(IN_BIT, WEIGHT_BIT, NUM_IN);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MAC    = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

endpackage

// File: rtl/nn1_relu_quant.sv
// ReLU, arithmetic right shift and unsigned saturation to OUT_W bits.
// Purely combinational so every layer can reuse it.
module nn1_relu_quant #(
    parameter int IN_W  = 15,
    parameter int OUT_W = 4,
    parameter int SHIFT = 3
) (
    input  logic signed [IN_W-1:0] s,
    output logic        [OUT_W-1:0] q
);

    logic signed [IN_W-1:0] sh;

    assign sh = s >>> SHIFT;

    // Only strictly positive sums pass; shifted value is then non-negative.
    always_comb begin
        q = '0;
        if (!s[IN_W-1] && (|s)) begin
            if (|sh[IN_W-1:OUT_W])
                q = '1;
            else
                q = sh[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_nn1_layer2.sv
// Sequential multiply-accumulate neuron: one input per cycle,
// then bias, ReLU and requantization in a single finish cycle.
module neuron_nn1_layer2 #(
    parameter int NUM_IN     = nn1_pkg::NUM_IN,
    parameter int IN_BIT     = nn1_pkg::IN_BIT,
    parameter int WEIGHT_BIT = nn1_pkg::WEIGHT_BIT,
    parameter int BIAS_BIT   = nn1_pkg::BIAS_BIT,
    parameter int OUT_BIT    = nn1_pkg::OUT_BIT,
    parameter int SHIFT      = nn1_pkg::SHIFT
) (
    input  logic                         clk3,
    input  logic                         reset2,
    input  logic                         start,
    input  logic [NUM_IN*IN_BIT-1:0]     in_features,
    input  logic [NUM_IN*WEIGHT_BIT-1:0] in_weights,
    input  logic [BIAS_BIT-1:0]          bias,
    output logic                         busy,
    output logic [OUT_BIT-1:0]           out,
    output logic                         out_valid
);

    import nn1_pkg::*;

    localparam int ACC_W  = acc_width(IN_BIT, WEIGHT_BIT, NUM_IN);
    localparam int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int PROD_W = IN_BIT + WEIGHT_BIT + 1;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t                         state;
    logic [NUM_IN*IN_BIT-1:0]       feat_q;
    logic [NUM_IN*WEIGHT_BIT-1:0]   wt_q;
    logic [BIAS_BIT-1:0]            bias_q;
    logic signed [ACC_W-1:0]        acc;
    logic [IDX_W-1:0]               idx;

    logic signed [PROD_W-1:0]       f_ext;
    logic signed [PROD_W-1:0]       w_ext;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        acc_next;
    logic signed [SUM_W-1:0]        sum;
    logic [OUT_BIT-1:0]             q;

    // Captured vectors shift down one element per MAC cycle,
    // so element 0 is always the current term.
    assign f_ext = {{(PROD_W-IN_BIT){1'b0}}, feat_q[IN_BIT-1:0]};
    assign w_ext = {{(PROD_W-WEIGHT_BIT){wt_q[WEIGHT_BIT-1]}},
                    wt_q[WEIGHT_BIT-1:0]};
    assign prod  = f_ext * w_ext;

    assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    assign sum = {acc[ACC_W-1], acc}
               + {{(SUM_W-BIAS_BIT){bias_q[BIAS_BIT-1]}}, bias_q};

    nn1_relu_quant #(
        .IN_W  (SUM_W),
        .OUT_W (OUT_BIT),
        .SHIFT (SHIFT)
    ) u_relu_quant (
        .s (sum),
        .q (q)
    );

    always_ff @(posedge clk3 or posedge reset2) begin
        if (reset2) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            feat_q    <= '0;
            wt_q      <= '0;
            bias_q    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        feat_q <= in_features;
                        wt_q   <= in_weights;
                        bias_q <= bias;
                        acc    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    feat_q <= feat_q >> IN_BIT;
                    wt_q   <= wt_q >> WEIGHT_BIT;
                    acc    <= acc_next;
                    idx    <= idx + IDX_ONE;
                    if (idx == IDX_LAST)
                        state <= ST_FINISH;
                end
                ST_FINISH: begin
                    out       <= q;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_nn1_layer2.sv
// Directed scoreboard bench for neuron_nn1_layer2: latency, saturation,
// ReLU, index boundaries, start handling and mid-MAC reset.
module tb_neuron_nn1_layer2;

    localparam int NI = 32;
    localparam int IB = 4;
    localparam int WB = 4;
    localparam int BB = 6;
    localparam int OB = 4;
    localparam int LAT = NI + 1;

    logic              clk3 = 1'b0;
    logic              reset2;
    logic              start;
    logic [NI*IB-1:0]  in_features;
    logic [NI*WB-1:0]  in_weights;
    logic [BB-1:0]     bias;
    logic              busy;
    logic [OB-1:0]     out;
    logic              out_valid;

    int errors = 0;
    int checks = 0;
    logic [OB-1:0] sb[$];

    always #5 clk3 = ~clk3;

    neuron_nn1_layer2 dut (
        .clk3        (clk3),
        .reset2      (reset2),
        .start       (start),
        .in_features (in_features),
        .in_weights  (in_weights),
        .bias        (bias),
        .busy        (busy),
        .out         (out),
        .out_valid   (out_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk3);
        #1;
    endtask

    function automatic logic [OB-1:0] model(input logic [NI*IB-1:0] f,
                                            input logic [NI*WB-1:0] w,
                                            input logic [BB-1:0] b);
        int s;
        s = int'($signed(b));
        for (int i = 0; i < NI; i++)
            s += int'(f[i*IB +: IB]) * int'($signed(w[i*WB +: WB]));
        if (s <= 0) return '0;
        s = s >>> 3;
        if (s > 15) return 4'd15;
        return OB'(s);
    endfunction

    task automatic load(input logic [NI*IB-1:0] f,
                        input logic [NI*WB-1:0] w,
                        input logic [BB-1:0] b);
        in_features = f;
        in_weights  = w;
        bias        = b;
    endtask

    task automatic scramble();
        in_features = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_weights  = {$urandom(), $urandom(), $urandom(), $urandom()};
        bias        = BB'($urandom());
    endtask

    task automatic start_eval(input string tag,
                              input logic [NI*IB-1:0] f,
                              input logic [NI*WB-1:0] w,
                              input logic [BB-1:0] b);
        load(f, w, b);
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(model(f, w, b));
        check({tag, "_busy"}, busy, 1);
        scramble();
    endtask

    // Wait for out_valid, compare latency and value, then the pulse end.
    task automatic wait_result(input string tag, input int exp_lat);
        int n;
        logic [OB-1:0] exp;
        n = 0;
        while (!out_valid && n < 2 * LAT) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        if (out_valid && sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, "_out"}, out, exp);
            check({tag, "_busy_clr"}, busy, 0);
            tick();
            check({tag, "_vld_clr"}, out_valid, 0);
            check({tag, "_hold"}, out, exp);
        end else begin
            check({tag, "_got_result"}, 0, 1);
        end
    endtask

    initial begin
        logic [NI*IB-1:0] f;
        logic [NI*WB-1:0] w;
        int seen;

        reset2 = 1'b1;
        start  = 1'b0;
        load('0, '0, '0);
        tick();
        tick();
        check("rst_out", out, 0);
        check("rst_vld", out_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk3);
        reset2 = 1'b0;
        tick();

        start_eval("zero_feat", '0, {NI{4'd5}}, 6'd31);
        wait_result("zero_feat", LAT);

        start_eval("sat", {NI{4'd15}}, {NI{4'd7}}, 6'd0);
        wait_result("sat", LAT);

        start_eval("relu", {NI{4'd15}}, {NI{4'b1000}}, 6'd31);
        wait_result("relu", LAT);

        f = '0;
        f[31*IB +: IB] = 4'd8;
        w = {NI{4'b1001}};
        w[31*WB +: WB] = 4'd3;
        start_eval("idx_last", f, w, 6'd0);
        wait_result("idx_last", LAT);

        f = '0;
        f[0 +: IB] = 4'd8;
        w = {NI{4'b1001}};
        w[0 +: WB] = 4'd3;
        start_eval("idx_first", f, w, 6'd0);
        wait_result("idx_first", LAT);

        for (int k = 0; k < 3; k++) begin
            f = {$urandom(), $urandom(), $urandom(), $urandom()};
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_eval("rand", f, w, BB'($urandom()));
            wait_result("rand", LAT);
        end

        // start re-pulsed mid-MAC must be ignored
        start_eval("restart", {NI{4'd9}}, {NI{4'd2}}, 6'd5);
        repeat (10) tick();
        load({NI{4'd15}}, {NI{4'd7}}, 6'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_result("restart", LAT - 11);
        seen = 0;
        for (int c = 0; c < 2 * LAT; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("restart_single", seen, 0);
        check("restart_idle", busy, 0);

        // start held high across a whole evaluation into the out_valid cycle
        f = {NI{4'd3}};
        w = {NI{4'd1}};
        load(f, w, 6'd2);
        start = 1'b1;
        tick();
        sb.push_back(model(f, w, 6'd2));
        check("b2b_a_busy", busy, 1);
        f = {NI{4'd15}};
        w = {NI{4'd1}};
        load(f, w, 6'd0);
        seen = 0;
        while (!out_valid && seen < 2 * LAT) begin
            tick();
            seen++;
        end
        check("b2b_a_lat", seen, LAT);
        check("b2b_a_out", out, sb.size() > 0 ? sb.pop_front() : 4'hx);
        tick();
        sb.push_back(model(f, w, 6'd0));
        start = 1'b0;
        scramble();
        check("b2b_b_busy", busy, 1);
        check("b2b_b_vld_clr", out_valid, 0);
        wait_result("b2b_b", LAT);

        // asynchronous reset in the middle of MAC
        start_eval("mid_rst", {NI{4'd4}}, {NI{4'd1}}, 6'd0);
        repeat (15) tick();
        #2;
        reset2 = 1'b1;
        #1;
        check("mid_rst_out", out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_vld", out_valid, 0);
        void'(sb.pop_back());
        @(negedge clk3);
        reset2 = 1'b0;
        seen = 0;
        for (int c = 0; c < 2 * LAT; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_vld", seen, 0);
        check("mid_rst_out_kept", out, 0);

        start_eval("post_rst", {NI{4'd6}}, {NI{4'd1}}, 6'd4);
        wait_result("post_rst", LAT);

        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
